sar_search_4b: RTL and testbench

SAR_SEARCH_4B -- requirements
Module: sar_search_4b

---
 rtl/sar_search_4b.sv | 110 +++++++++++
 tb/tb_sar_search_4b.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/sar_search_4b.sv
// 4-bit successive-approximation search controller driving an external comparator.
// MSB-first trial on GUESS, optional settle wait per trial, one-cycle DONE with RESULT/ERR.
module sar_search_4b #(
    parameter int SETTLE = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       GT,
    input  logic       LT,
    input  logic       EQ,
    output logic [3:0] GUESS,
    output logic [3:0] RESULT,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);
    typedef enum logic [1:0] {IDLE, WAIT, CMP, FIN} state_t;

    // After a new trial value, either settle first or compare immediately.
    localparam state_t     STEP     = (SETTLE > 0) ? WAIT : CMP;
    localparam logic [2:0] CNT_LAST = (SETTLE > 0) ? 3'(SETTLE - 1) : 3'd0;

    state_t     state, state_nxt;
    logic [3:0] acc, acc_nxt, acc_upd, res_nxt;
    logic [1:0] idx, idx_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       err_nxt, flags_ok;

    assign GUESS = acc;

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        res_nxt   = RESULT;
        err_nxt   = ERR;
        flags_ok  = ({GT, LT, EQ} == 3'b100) || ({GT, LT, EQ} == 3'b010) ||
                    ({GT, LT, EQ} == 3'b001);
        acc_upd   = acc;
        if (LT)
            acc_upd[idx] = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    acc_nxt   = 4'b1000;
                    idx_nxt   = 2'd3;
                    err_nxt   = 1'b0;
                    cnt_nxt   = 3'd0;
                    state_nxt = STEP;
                end
            end
            WAIT: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = 3'd0;
                    state_nxt = CMP;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            CMP: begin
                if (!flags_ok) begin
                    err_nxt   = 1'b1;
                    res_nxt   = 4'h0;
                    state_nxt = FIN;
                end else if (EQ) begin
                    res_nxt   = acc;
                    state_nxt = FIN;
                end else if (idx == 2'd0) begin
                    acc_nxt   = acc_upd;
                    res_nxt   = acc_upd;
                    state_nxt = FIN;
                end else begin
                    // Resolve the current bit and set the next lower trial bit.
                    acc_nxt   = acc_upd | (4'b0001 << (idx - 2'd1));
                    idx_nxt   = idx - 2'd1;
                    cnt_nxt   = 3'd0;
                    state_nxt = STEP;
                end
            end
            FIN: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= 4'h0;
            idx    <= 2'd0;
            cnt    <= 3'd0;
            RESULT <= 4'h0;
            ERR    <= 1'b0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            idx    <= idx_nxt;
            cnt    <= cnt_nxt;
            RESULT <= res_nxt;
            ERR    <= err_nxt;
            // Status flags are registered from the next state so they align with it.
            BUSY   <= (state_nxt == WAIT) || (state_nxt == CMP);
            DONE   <= (state_nxt == FIN);
        end
    end
endmodule

// File: tb/tb_sar_search_4b.sv
// Directed bench for sar_search_4b: SETTLE=0 and SETTLE=2 instances, each with a model comparator.
module tb_sar_search_4b;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0, start2 = 1'b0;
    logic [3:0] tgt0 = 4'h0, tgt2 = 4'h0;
    logic       force_err = 1'b0;
    logic       gt0, lt0, eq0, gt2, lt2, eq2;
    logic [3:0] guess0, result0, guess2, result2;
    logic       busy0, done0, err0, busy2, done2, err2;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign gt0 = force_err | (tgt0 > guess0);
    assign lt0 = force_err | (tgt0 < guess0);
    assign eq0 = !force_err && (tgt0 == guess0);
    assign gt2 = tgt2 > guess2;
    assign lt2 = tgt2 < guess2;
    assign eq2 = tgt2 == guess2;

    sar_search_4b #(.SETTLE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .GT(gt0), .LT(lt0), .EQ(eq0),
        .GUESS(guess0), .RESULT(result0), .BUSY(busy0), .DONE(done0), .ERR(err0)
    );

    sar_search_4b #(.SETTLE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .GT(gt2), .LT(lt2), .EQ(eq2),
        .GUESS(guess2), .RESULT(result2), .BUSY(busy2), .DONE(done2), .ERR(err2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start one search; lat = cycles from the accepting edge to the DONE cycle (0 = none),
    // gseq = GUESS shifted in on every BUSY cycle.
    task automatic run(input bit sel, input logic [3:0] tgt, input bit hold,
                       output int lat, output logic [63:0] gseq);
        gseq = 64'h0;
        lat  = 0;
        @(negedge clk);
        if (sel) begin tgt2 = tgt; start2 = 1'b1; end
        else     begin tgt0 = tgt; start0 = 1'b1; end
        @(posedge clk);
        #1;
        if (!hold) begin start0 = 1'b0; start2 = 1'b0; end
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (sel ? done2 : done0) begin
                lat = c;
                break;
            end
            if (sel ? busy2 : busy0)
                gseq = {gseq[59:0], (sel ? guess2 : guess0)};
        end
    endtask

    initial begin
        int          lat;
        logic [63:0] g;
        bit          seen;

        #1;
        check("rst_dut0", {guess0, result0, busy0, done0, err0}, 11'h0);
        check("rst_dut2", {guess2, result2, busy2, done2, err2}, 11'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Target 5: full four-step search.
        run(1'b0, 4'd5, 1'b0, lat, g);
        check("t5_seq", g, 64'h8465);
        check("t5_lat", 64'(lat), 64'd5);
        check("t5_res", {result0, err0, busy0}, {4'd5, 1'b0, 1'b0});
        @(negedge clk);
        check("t5_done_once", done0, 1'b0);

        // Target 0: all LT.
        run(1'b0, 4'd0, 1'b0, lat, g);
        check("t0_seq", g, 64'h8421);
        check("t0_lat", 64'(lat), 64'd5);
        check("t0_res", result0, 4'd0);

        // Target 15: EQ on the last trial.
        run(1'b0, 4'd15, 1'b0, lat, g);
        check("t15_seq", g, 64'h8CEF);
        check("t15_lat", 64'(lat), 64'd5);
        check("t15_res", result0, 4'hF);

        // Target 10: early exit after three compares.
        run(1'b0, 4'd10, 1'b0, lat, g);
        check("t10_seq", g, 64'h8CA);
        check("t10_lat", 64'(lat), 64'd4);
        check("t10_res", result0, 4'hA);

        // SETTLE=2: each trial held three cycles.
        run(1'b1, 4'd5, 1'b0, lat, g);
        check("s2_seq", g, 64'h888444666555);
        check("s2_lat", 64'(lat), 64'd13);
        check("s2_res", {result2, err2}, {4'd5, 1'b0});
        check("s2_guess_at_done", guess2, 4'd5);

        // Non-one-hot flags at the first compare.
        force_err = 1'b1;
        run(1'b0, 4'd7, 1'b0, lat, g);
        check("err_lat", 64'(lat), 64'd2);
        check("err_flags", {err0, result0}, {1'b1, 4'h0});
        @(negedge clk);
        check("err_done_once", done0, 1'b0);
        check("err_held", err0, 1'b1);
        force_err = 1'b0;
        run(1'b0, 4'd3, 1'b0, lat, g);
        check("err_cleared", {err0, result0}, {1'b0, 4'd3});

        // start held high: ignored while busy, restarts after FIN.
        run(1'b0, 4'd10, 1'b1, lat, g);
        check("hold_seq", g, 64'h8CA);
        check("hold_lat", 64'(lat), 64'd4);
        @(negedge clk);
        check("hold_idle", busy0, 1'b0);
        @(negedge clk);
        check("hold_restart", {busy0, guess0}, {1'b1, 4'h8});
        start0 = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = done0;
        end
        check("hold_second_done", {seen, result0}, {1'b1, 4'hA});

        // Reset on the second compare cycle.
        @(negedge clk);
        tgt0 = 4'd7;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_outs", {guess0, result0, busy0, done0, err0}, 11'h0);
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen = seen | done0 | busy0;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            seen = seen | done0 | busy0;
        end
        check("midrst_quiet", seen, 1'b0);
        run(1'b0, 4'd9, 1'b0, lat, g);
        check("t9_seq", g, 64'h8CA9);
        check("t9_lat", 64'(lat), 64'd5);
        check("t9_res", {result0, err0}, {4'd9, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
